// File: rtl/prng_rand_scheduler.sv
// rtl/prng_rand_scheduler.sv - seeding/warm-up/reseed sequencer and round-robin arbiter for a dual-output PRNG
module prng_rand_scheduler #(
   parameter int RADIX         = 64,
   parameter int NUM_REQ       = 4,
   parameter int RESEED_LIMIT  = 1024,
   parameter int WARMUP_CYCLES = 2
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               enable,
   output logic               seed_req,
   input  logic               seed_ack,
   input  logic [RADIX-1:0]   seed_in1,
   input  logic [RADIX-1:0]   seed_in2,
   output logic               prng_on,
   output logic [RADIX-1:0]   prng_seed1,
   output logic [RADIX-1:0]   prng_seed2,
   input  logic [RADIX-1:0]   prng_rnd1,
   input  logic [RADIX-1:0]   prng_rnd2,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [RADIX-1:0]   rnd_out1,
   output logic [RADIX-1:0]   rnd_out2,
   output logic               ready,
   output logic               seed_err
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W  = $clog2(RESEED_LIMIT + 1);
   localparam int WARM_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEED_REQ, S_WARMUP, S_SERVE, S_RESEED
   } state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]   served_cnt;
   logic [WARM_W-1:0]  warm_cnt;
   logic [PTR_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant_vec;
   logic               grant_any;
   logic               do_grant;
   logic               seed_zero;
   logic               seed_take;
   logic               at_limit;
   logic               last_grant;

   assign seed_zero  = (seed_in1 == '0) || (seed_in2 == '0);
   assign seed_take  = (state == S_SEED_REQ) && enable && seed_ack && !seed_zero;
   assign at_limit   = (served_cnt == CNT_W'(RESEED_LIMIT));
   assign do_grant   = (state == S_SERVE) && enable && grant_any && !at_limit;
   assign last_grant = do_grant && (served_cnt == CNT_W'(RESEED_LIMIT - 1));

   assign seed_req = (state == S_SEED_REQ);
   assign prng_on  = (state == S_WARMUP) || (state == S_SERVE);
   assign ready    = (state == S_SERVE);

   // Scan from the farthest offset down so the nearest set bit at/after rr_ptr wins.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      grant_vec = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(idx);
         end
      end
      if (grant_any) grant_vec[grant_idx] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (enable) state_nxt = S_SEED_REQ;
         S_SEED_REQ: if (!enable) state_nxt = S_IDLE;
                     else if (seed_take) state_nxt = S_WARMUP;
         S_WARMUP:   if (!enable) state_nxt = S_IDLE;
                     else if (warm_cnt == WARM_W'(WARMUP_CYCLES)) state_nxt = S_SERVE;
         S_SERVE:    if (!enable) state_nxt = S_IDLE;
                     else if (at_limit || last_grant) state_nxt = S_RESEED;
         S_RESEED:   state_nxt = enable ? S_SEED_REQ : S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         served_cnt <= '0;
         warm_cnt   <= '0;
         prng_seed1 <= '0;
         prng_seed2 <= '0;
         gnt        <= '0;
         rnd_out1   <= '0;
         rnd_out2   <= '0;
         seed_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         seed_err <= (state == S_SEED_REQ) && enable && seed_ack && seed_zero;
         warm_cnt <= (state == S_WARMUP) ? warm_cnt + WARM_W'(1) : '0;
         if (seed_take) begin
            prng_seed1 <= seed_in1;
            prng_seed2 <= seed_in2;
         end
         // Unused PRNG words are never exposed: outputs are zero unless granted.
         if (do_grant) begin
            gnt        <= grant_vec;
            rnd_out1   <= prng_rnd1;
            rnd_out2   <= prng_rnd2;
            rr_ptr     <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            served_cnt <= served_cnt + CNT_W'(1);
         end else begin
            gnt      <= '0;
            rnd_out1 <= '0;
            rnd_out2 <= '0;
         end
         if (state == S_RESEED) served_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_prng_rand_scheduler.sv
// tb/tb_prng_rand_scheduler.sv - directed bench with a behavioural xorshift PRNG stand-in
module tb_prng_rand_scheduler;

   localparam int RADIX = 16;
   localparam int NR    = 4;

   logic             clock = 1'b0;
   logic             rst_n, enable, seed_ack;
   logic [RADIX-1:0] seed_in1, seed_in2;
   logic             seed_req, prng_on, ready, seed_err;
   logic [RADIX-1:0] prng_seed1, prng_seed2, prng_rnd1, prng_rnd2, rnd_out1, rnd_out2;
   logic [NR-1:0]    req, gnt;
   logic             prng_run;

   int total = 0;
   int bad   = 0;
   logic [2*RADIX-1:0] pairs[$];

   always #5 clock = ~clock;

   prng_rand_scheduler #(
      .RADIX(RADIX), .NUM_REQ(NR), .RESEED_LIMIT(4), .WARMUP_CYCLES(2)
   ) dut (
      .clock(clock), .rst_n(rst_n), .enable(enable),
      .seed_req(seed_req), .seed_ack(seed_ack), .seed_in1(seed_in1), .seed_in2(seed_in2),
      .prng_on(prng_on), .prng_seed1(prng_seed1), .prng_seed2(prng_seed2),
      .prng_rnd1(prng_rnd1), .prng_rnd2(prng_rnd2),
      .req(req), .gnt(gnt), .rnd_out1(rnd_out1), .rnd_out2(rnd_out2),
      .ready(ready), .seed_err(seed_err)
   );

   function automatic logic [RADIX-1:0] xs(input logic [RADIX-1:0] x);
      logic [RADIX-1:0] y;
      y = x ^ (x << 7);
      y = y ^ (y >> 9);
      y = y ^ (y << 8);
      return y;
   endfunction

   // PRNG contract: seeds one cycle after prng_on rises, then advance every cycle.
   always_ff @(posedge clock) begin
      if (!prng_on) begin
         prng_rnd1 <= '0;
         prng_rnd2 <= '0;
         prng_run  <= 1'b0;
      end else if (!prng_run) begin
         prng_rnd1 <= prng_seed1;
         prng_rnd2 <= prng_seed2;
         prng_run  <= 1'b1;
      end else begin
         prng_rnd1 <= xs(prng_rnd1);
         prng_rnd2 <= xs(prng_rnd2);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_outs"}, {seed_req, prng_on, ready, seed_err, gnt}, '0);
      chk({tag, "_data"}, {prng_seed1, prng_seed2, rnd_out1, rnd_out2}, '0);
   endtask

   // Hold expected gnt for one grant; expected words are the PRNG words seen before the edge.
   task automatic grant_step(input string tag, input logic [NR-1:0] exp_g);
      logic [RADIX-1:0] e1, e2;
      logic dup;
      e1 = prng_rnd1;
      e2 = prng_rnd2;
      tick();
      chk({tag, "_gnt"}, gnt, exp_g);
      chk({tag, "_rnd"}, {rnd_out1, rnd_out2}, {e1, e2});
      dup = 1'b0;
      foreach (pairs[i]) if (pairs[i] == {e1, e2}) dup = 1'b1;
      chk({tag, "_uniq"}, dup, 1'b0);
      pairs.push_back({e1, e2});
   endtask

   task automatic accept_and_warm(input logic [RADIX-1:0] s1, input logic [RADIX-1:0] s2, input string tag);
      seed_ack = 1'b1; seed_in1 = s1; seed_in2 = s2;
      tick();
      seed_ack = 1'b0;
      chk({tag, "_seedreq_drop"}, seed_req, 1'b0);
      chk({tag, "_on"}, prng_on, 1'b1);
      chk({tag, "_seeds"}, {prng_seed1, prng_seed2}, {s1, s2});
      for (int k = 0; k < 3; k++) begin
         chk({tag, "_nognt"}, gnt, '0);
         chk({tag, "_ready_pre"}, ready, 1'b0);
         tick();
      end
      chk({tag, "_ready"}, ready, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; seed_ack = 1'b0;
      seed_in1 = '0; seed_in2 = '0; req = '0;
      #2;
      all_zero("rst");
      tick(); tick();
      rst_n = 1'b1;
      enable = 1'b1;
      tick();
      chk("seedreq_up", {seed_req, prng_on}, 2'b10);
      accept_and_warm(16'h0001, 16'h0002, "w1");

      req = 4'b1111;
      grant_step("rr0", 4'b0001);
      grant_step("rr1", 4'b0010);
      grant_step("rr2", 4'b0100);
      grant_step("rr3", 4'b1000);
      chk("reseed_on", {prng_on, ready}, 2'b00);
      tick();
      chk("reseed_seedreq", {seed_req, prng_on}, 2'b10);
      chk("reseed_nognt", {gnt, rnd_out1, rnd_out2}, '0);

      seed_ack = 1'b1; seed_in1 = '0; seed_in2 = 16'h0005;
      tick();
      seed_ack = 1'b0;
      chk("zero_err", {seed_err, seed_req, prng_on}, 3'b110);
      tick();
      chk("zero_err_end", {seed_err, seed_req}, 2'b01);
      accept_and_warm(16'h0003, 16'h0004, "w2");

      grant_step("rr4", 4'b0001);
      req = 4'b0100;
      grant_step("one_a", 4'b0100);
      grant_step("one_b", 4'b0100);
      req = 4'b0000;
      tick();
      chk("idle_req", {gnt, rnd_out1, rnd_out2}, '0);
      chk("idle_ready", ready, 1'b1);

      req = 4'b0001;
      enable = 1'b0;
      tick();
      chk("drop_gnt", {gnt, rnd_out1, rnd_out2}, '0);
      chk("drop_state", {prng_on, ready, seed_req}, 3'b000);

      req = '0;
      enable = 1'b1;
      tick();
      seed_ack = 1'b1; seed_in1 = 16'h0007; seed_in2 = 16'h0009;
      tick();
      seed_ack = 1'b0;
      chk("w3_on", prng_on, 1'b1);
      enable = 1'b0;
      rst_n = 1'b0;
      #1;
      all_zero("async_rst");
      tick();
      rst_n = 1'b1;
      tick();
      all_zero("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
